vector_checker: RTL and testbench
=================================

Name: vector_checker

Overview:
Synthesizable, parametrised test-vector sequencer and self-checker for combinational DUTs. Vectors are loaded into an internal memory through a write port. On a start pulse the block drives each vector's inputs into the DUT and waits a programmable settle time. It then compares the DUT outputs against expected values under a per-bit care mask, counting errors and capturing the first failure. It sits beside a DUT in on-board or bench self-test and replaces ad-hoc file-driven checking with a reusable engine.

Parameters:
NIN, 3, DUT input width (bits), >=1
NOUT, 1, DUT output width (bits), >=1
DEPTH, 1024, vector memory entries, power of 2, >=2
AW, $clog2(DEPTH), address width
SETTLE, 2, cycles each vector is held before sampling, >=1
EW, 16, error/vector counter width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state except vector memory
load_en  in  1  write vector memory (ignored while busy)
load_addr  in  AW  write address
load_data  in  1+NIN+2*NOUT  {valid, inputs, expected, care_mask}
start  in  1  one-cycle pulse, begins run (ignored while busy)
stop_on_err  in  1  sampled at start; 1 = halt after first mismatch
dut_out  in  NOUT  DUT outputs
dut_in  out  NIN  registered DUT inputs
busy  out  1  run in progress
done  out  1  run finished, held until next start
pass  out  1  done && err_count==0
err_count  out  EW  mismatching vectors, saturating
vec_count  out  EW  vectors checked, saturating
fail_valid  out  1  a failure has been captured
fail_index  out  AW  address of first failing vector
fail_got  out  NOUT  dut_out at first failure

Behaviour:
- Reset values: dut_in=0, busy=0, done=0, pass=0, err_count=0, vec_count=0, fail_valid=0, fail_index=0, fail_got=0, state=IDLE, index=0, settle counter=0. Memory contents are untouched by reset; memory powers up with valid=0.
- States: IDLE, APPLY, CHECK, DONE.
- IDLE/DONE + start:
  - index<=0; counters, fail_* and done clear; stop_on_err latched.
  - If mem[0].valid=0, go to DONE (vec_count=0, pass=1). Otherwise dut_in<=mem[0].inputs and go to APPLY.
- APPLY: hold dut_in for SETTLE cycles (counter SETTLE-1 down to 0), then go to CHECK.
- CHECK (one cycle):
  - Mismatch = |((dut_out ^ expected) & care_mask). Mask bit 1 = compare; mask all-zero = vector always passes.
  - vec_count+1. On mismatch, err_count+1; if fail_valid=0, set fail_valid and capture fail_index=index, fail_got=dut_out.
  - Go to DONE if any of: index==DEPTH-1; mem[index+1].valid=0; mismatch && stop_on_err.
  - Otherwise index+1, dut_in<=mem[index+1].inputs, return to APPLY.
- Timing: each vector occupies SETTLE+1 cycles. dut_in changes on the clock edge entering APPLY.
- busy=1 in APPLY and CHECK. done=1 only in DONE. dut_in holds its last value in DONE.
- Counters saturate at 2^EW-1; no wrap.
- load_en during busy: write dropped. Loading during IDLE/DONE is allowed and does not affect done/results.
- start while busy: ignored. start in DONE: restarts the run.
- Memory read is combinational from the register array. A write to address A and a CHECK of A never coincide because writes are blocked while busy.
- reset asserted mid-run: all outputs return to reset values immediately (asynchronous). The run is abandoned; memory is kept.

Test Plan:
- Load 8 vectors implementing y=~a&~b | a&~c (NIN=3, NOUT=1, full mask), valid=0 at addr 8, correct DUT -> done after 8*(SETTLE+1)+1 cycles from start, vec_count=8, err_count=0, pass=1, fail_valid=0.
- Same vectors with addr 3 expected flipped, stop_on_err=0 -> vec_count=8, err_count=1, fail_index=3, fail_got=DUT value, pass=0.
- Addr 2 and 5 wrong, stop_on_err=1 -> done right after vector 2's CHECK, vec_count=3, err_count=1, fail_index=2, dut_in holds vector 2 inputs.
- Mask 0 on a deliberately wrong expected bit -> no error counted. Also: mem[0].valid=0 -> done next cycle, vec_count=0, pass=1.
- All DEPTH entries valid (DEPTH=4) -> stops after index 3, vec_count=4, no index wrap. load_en during run -> memory unchanged (verify by rerun). start while busy -> no restart.
- reset pulsed in APPLY of vector 4 -> busy/done/counters/dut_in=0 asynchronously. A new start then completes normally with the memory intact.

Source files
------------

// File: rtl/vector_checker.sv
// Test-vector sequencer and self-checker for a combinational DUT: replays stored
// vectors onto dut_in, waits a settle time, then compares dut_out under a care mask.
module vector_checker #(
  parameter int NIN    = 3,
  parameter int NOUT   = 1,
  parameter int DEPTH  = 1024,
  parameter int AW     = $clog2(DEPTH),
  parameter int SETTLE = 2,
  parameter int EW     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic [AW-1:0]         load_addr,
  input  logic [NIN+2*NOUT:0]   load_data,
  input  logic                  start,
  input  logic                  stop_on_err,
  input  logic [NOUT-1:0]       dut_out,
  output logic [NIN-1:0]        dut_in,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [EW-1:0]         err_count,
  output logic [EW-1:0]         vec_count,
  output logic                  fail_valid,
  output logic [AW-1:0]         fail_index,
  output logic [NOUT-1:0]       fail_got
);

  localparam int W  = 1 + NIN + 2 * NOUT;
  localparam int SW = $clog2(SETTLE + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] APPLY = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [AW-1:0] LAST_INDEX  = AW'(DEPTH - 1);

  // Entry layout: {valid, inputs, expected, care_mask}
  function automatic logic ent_valid(input logic [W-1:0] e);
    return e[W-1];
  endfunction

  function automatic logic [NIN-1:0] ent_inputs(input logic [W-1:0] e);
    return e[W-2 -: NIN];
  endfunction

  function automatic logic ent_mismatch(input logic [W-1:0] e, input logic [NOUT-1:0] got);
    return |((got ^ e[2*NOUT-1 -: NOUT]) & e[NOUT-1:0]);
  endfunction

  function automatic logic [EW-1:0] sat_inc(input logic [EW-1:0] v);
    return (&v) ? v : v + EW'(1);
  endfunction

  logic [W-1:0]    mem_r [DEPTH];
  logic [1:0]      state_r, state_s;
  logic [AW-1:0]   index_r, index_s;
  logic [SW-1:0]   settle_r, settle_s;
  logic            stop_r, stop_s;
  logic [NIN-1:0]  dut_in_r, dut_in_s;
  logic            busy_r, busy_s;
  logic            done_r, done_s;
  logic            pass_r, pass_s;
  logic [EW-1:0]   err_r, err_s;
  logic [EW-1:0]   vec_r, vec_s;
  logic            fail_valid_r, fail_valid_s;
  logic [AW-1:0]   fail_index_r, fail_index_s;
  logic [NOUT-1:0] fail_got_r, fail_got_s;

  logic            first_valid_s, next_valid_s, mismatch_s;
  logic [NIN-1:0]  first_inputs_s, next_inputs_s;

  assign first_valid_s  = ent_valid(mem_r[0]);
  assign first_inputs_s = ent_inputs(mem_r[0]);
  assign next_valid_s   = ent_valid(mem_r[index_r + AW'(1)]);
  assign next_inputs_s  = ent_inputs(mem_r[index_r + AW'(1)]);
  assign mismatch_s     = ent_mismatch(mem_r[index_r], dut_out);

  // Vector memory write port; blocked during a run so CHECK never races a write.
  always_ff @(posedge clk) begin
    if (load_en && !busy_r) begin
      mem_r[load_addr] <= load_data;
    end else begin
      mem_r[load_addr] <= mem_r[load_addr];
    end
  end

  // Sequencer next-state and result bookkeeping.
  always_comb begin
    state_s      = state_r;
    index_s      = index_r;
    settle_s     = settle_r;
    stop_s       = stop_r;
    dut_in_s     = dut_in_r;
    err_s        = err_r;
    vec_s        = vec_r;
    fail_valid_s = fail_valid_r;
    fail_index_s = fail_index_r;
    fail_got_s   = fail_got_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          index_s      = {AW{1'b0}};
          stop_s       = stop_on_err;
          err_s        = {EW{1'b0}};
          vec_s        = {EW{1'b0}};
          fail_valid_s = 1'b0;
          fail_index_s = {AW{1'b0}};
          fail_got_s   = {NOUT{1'b0}};
          if (first_valid_s) begin
            dut_in_s = first_inputs_s;
            settle_s = SETTLE_LAST;
            state_s  = APPLY;
          end else begin
            state_s  = DONE;
          end
        end else begin
          state_s = state_r;
        end
      end
      APPLY: begin
        if (settle_r == {SW{1'b0}}) begin
          state_s = CHECK;
        end else begin
          settle_s = settle_r - SW'(1);
        end
      end
      CHECK: begin
        vec_s = sat_inc(vec_r);
        if (mismatch_s) begin
          err_s = sat_inc(err_r);
          if (!fail_valid_r) begin
            fail_valid_s = 1'b1;
            fail_index_s = index_r;
            fail_got_s   = dut_out;
          end else begin
            fail_valid_s = fail_valid_r;
          end
        end else begin
          err_s = err_r;
        end
        if ((index_r == LAST_INDEX) || !next_valid_s || (mismatch_s && stop_r)) begin
          state_s = DONE;
        end else begin
          index_s  = index_r + AW'(1);
          dut_in_s = next_inputs_s;
          settle_s = SETTLE_LAST;
          state_s  = APPLY;
        end
      end
      default: state_s = IDLE;
    endcase
    busy_s = (state_s == APPLY) || (state_s == CHECK);
    done_s = (state_s == DONE);
    pass_s = done_s && (err_s == {EW{1'b0}});
  end

  // State and registered outputs; memory is deliberately outside the reset domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      index_r      <= {AW{1'b0}};
      settle_r     <= {SW{1'b0}};
      stop_r       <= 1'b0;
      dut_in_r     <= {NIN{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      err_r        <= {EW{1'b0}};
      vec_r        <= {EW{1'b0}};
      fail_valid_r <= 1'b0;
      fail_index_r <= {AW{1'b0}};
      fail_got_r   <= {NOUT{1'b0}};
    end else begin
      state_r      <= state_s;
      index_r      <= index_s;
      settle_r     <= settle_s;
      stop_r       <= stop_s;
      dut_in_r     <= dut_in_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      pass_r       <= pass_s;
      err_r        <= err_s;
      vec_r        <= vec_s;
      fail_valid_r <= fail_valid_s;
      fail_index_r <= fail_index_s;
      fail_got_r   <= fail_got_s;
    end
  end

  assign dut_in     = dut_in_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign pass       = pass_r;
  assign err_count  = err_r;
  assign vec_count  = vec_r;
  assign fail_valid = fail_valid_r;
  assign fail_index = fail_index_r;
  assign fail_got   = fail_got_r;

endmodule

// File: tb/tb_vector_checker.sv
// Directed bench for vector_checker: DEPTH=16 instance for the main scenarios and a
// DEPTH=4 instance for the full-memory case, both checking y = ~a&~b | a&~c.
module tb_vector_checker;

  localparam int SETTLE = 2;
  // y for abc = 0..7 (bit i = y(i)): 1,1,0,0,1,0,1,0
  localparam logic [7:0] YTAB = 8'b0101_0011;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_en = 1'b0;
  logic [3:0]  load_addr = 4'd0;
  logic [5:0]  load_data = 6'd0;
  logic        start = 1'b0;
  logic        stop_on_err = 1'b0;
  logic [0:0]  dut_out;
  logic [2:0]  dut_in;
  logic        busy, done, pass, fail_valid;
  logic [15:0] err_count, vec_count;
  logic [3:0]  fail_index;
  logic [0:0]  fail_got;

  logic        l4_en = 1'b0;
  logic [1:0]  l4_addr = 2'd0;
  logic [5:0]  l4_data = 6'd0;
  logic        s4 = 1'b0;
  logic        s4_soe = 1'b0;
  logic [0:0]  d4_out;
  logic [2:0]  d4_in;
  logic        b4, dn4, p4, fv4;
  logic [15:0] e4, v4;
  logic [1:0]  fi4;
  logic [0:0]  fg4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign dut_out[0] = (~dut_in[2] & ~dut_in[1]) | (dut_in[2] & ~dut_in[0]);
  assign d4_out[0]  = (~d4_in[2] & ~d4_in[1]) | (d4_in[2] & ~d4_in[0]);

  vector_checker #(.NIN(3), .NOUT(1), .DEPTH(16), .SETTLE(SETTLE), .EW(16)) u_dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .stop_on_err(stop_on_err),
    .dut_out(dut_out), .dut_in(dut_in), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .vec_count(vec_count), .fail_valid(fail_valid),
    .fail_index(fail_index), .fail_got(fail_got)
  );

  vector_checker #(.NIN(3), .NOUT(1), .DEPTH(4), .SETTLE(SETTLE), .EW(16)) u_dut4 (
    .clk(clk), .reset(reset), .load_en(l4_en), .load_addr(l4_addr),
    .load_data(l4_data), .start(s4), .stop_on_err(s4_soe),
    .dut_out(d4_out), .dut_in(d4_in), .busy(b4), .done(dn4), .pass(p4),
    .err_count(e4), .vec_count(v4), .fail_valid(fv4),
    .fail_index(fi4), .fail_got(fg4)
  );

  task automatic load_vec(input int a, input logic v, input logic e, input logic m);
    logic [2:0] ins;
    ins = 3'(a);
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = 4'(a);
    load_data = {v, ins, e, m};
    @(posedge clk);
    #1 load_en = 1'b0;
  endtask

  // Vectors 0..7 with inputs = address, expected = YTAB ^ flip, then a terminator at 8.
  task automatic load_set(input logic [7:0] flip, input logic [7:0] mask);
    for (int i = 0; i < 8; i++) load_vec(i, 1'b1, YTAB[i] ^ flip[i], mask[i]);
    load_vec(8, 1'b0, 1'b0, 1'b0);
  endtask

  // Pulses start; cycles counts clock edges from the start-capturing edge until done.
  task automatic run(input logic soe, output int cycles);
    @(negedge clk);
    start = 1'b1;
    stop_on_err = soe;
    @(posedge clk);
    #1 start = 1'b0;
    cycles = 1;
    while (!done && cycles < 200) begin
      @(posedge clk);
      #1 cycles++;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, pass, fail_valid} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, pass, fail_valid});
    end
    checks++;
    if ({err_count, vec_count, fail_index, fail_got, dut_in} !== 40'd0) begin
      errors++; $display("FAIL reset_values got err=%0d vec=%0d idx=%0d got=%0d in=%0d exp all 0",
                        err_count, vec_count, fail_index, fail_got, dut_in);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_pass;
    int cyc;
    load_set(8'h00, 8'hFF);
    run(1'b0, cyc);
    checks++;
    if (cyc !== 8 * (SETTLE + 1) + 1) begin
      errors++; $display("FAIL pass_latency got=%0d exp=%0d", cyc, 8 * (SETTLE + 1) + 1);
    end
    checks++;
    if (vec_count !== 16'd8 || err_count !== 16'd0) begin
      errors++; $display("FAIL pass_counts got vec=%0d err=%0d exp vec=8 err=0", vec_count, err_count);
    end
    checks++;
    if ({pass, fail_valid, busy} !== 3'b100) begin
      errors++; $display("FAIL pass_flags got=%b exp=100", {pass, fail_valid, busy});
    end
  endtask

  task automatic test_single_error;
    int cyc;
    load_set(8'h08, 8'hFF);
    run(1'b0, cyc);
    checks++;
    if (cyc !== 25 || vec_count !== 16'd8 || err_count !== 16'd1) begin
      errors++; $display("FAIL single_counts got cyc=%0d vec=%0d err=%0d exp 25/8/1", cyc, vec_count, err_count);
    end
    checks++;
    if (fail_valid !== 1'b1 || fail_index !== 4'd3 || fail_got !== 1'b0 || pass !== 1'b0) begin
      errors++; $display("FAIL single_capture got fv=%b idx=%0d got=%b pass=%b exp 1/3/0/0",
                        fail_valid, fail_index, fail_got, pass);
    end
  endtask

  task automatic test_stop_on_err;
    int cyc;
    load_set(8'h24, 8'hFF);
    run(1'b1, cyc);
    checks++;
    if (cyc !== 3 * (SETTLE + 1) + 1 || vec_count !== 16'd3 || err_count !== 16'd1) begin
      errors++; $display("FAIL stop_counts got cyc=%0d vec=%0d err=%0d exp 10/3/1", cyc, vec_count, err_count);
    end
    checks++;
    if (fail_index !== 4'd2 || fail_got !== 1'b0 || dut_in !== 3'd2) begin
      errors++; $display("FAIL stop_capture got idx=%0d got=%b in=%0d exp 2/0/2", fail_index, fail_got, dut_in);
    end
  endtask

  task automatic test_mask;
    int cyc;
    load_set(8'h08, 8'hF7);
    run(1'b1, cyc);
    checks++;
    if (vec_count !== 16'd8 || err_count !== 16'd0 || pass !== 1'b1) begin
      errors++; $display("FAIL mask_ignore got vec=%0d err=%0d pass=%b exp 8/0/1", vec_count, err_count, pass);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    load_set(8'h00, 8'hFF);
    checks++;
    if ({done, pass} !== 2'b11) begin
      errors++; $display("FAIL load_in_done got done/pass=%b exp=11", {done, pass});
    end
    @(negedge clk);
    start = 1'b1;
    stop_on_err = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1;
    repeat (4) begin
      @(posedge clk);
      #1 cyc++;
    end
    start     = 1'b1;
    load_en   = 1'b1;
    load_addr = 4'd0;
    load_data = {1'b1, 3'd0, 1'b0, 1'b1};
    @(posedge clk);
    #1 cyc++;
    start   = 1'b0;
    load_en = 1'b0;
    while (!done && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
    end
    checks++;
    if (cyc !== 25 || vec_count !== 16'd8 || err_count !== 16'd0) begin
      errors++; $display("FAIL busy_ignore got cyc=%0d vec=%0d err=%0d exp 25/8/0", cyc, vec_count, err_count);
    end
    run(1'b0, cyc);
    checks++;
    if (err_count !== 16'd0 || vec_count !== 16'd8 || pass !== 1'b1) begin
      errors++; $display("FAIL mem_kept got err=%0d vec=%0d pass=%b exp 0/8/1", err_count, vec_count, pass);
    end
  endtask

  task automatic test_empty;
    int cyc;
    load_vec(0, 1'b0, 1'b0, 1'b0);
    run(1'b0, cyc);
    checks++;
    if (cyc !== 1 || vec_count !== 16'd0 || {done, pass, busy} !== 3'b110) begin
      errors++; $display("FAIL empty_run got cyc=%0d vec=%0d dpb=%b exp 1/0/110", cyc, vec_count, {done, pass, busy});
    end
  endtask

  task automatic test_full_depth;
    int cyc;
    logic [2:0] ins;
    for (int i = 0; i < 4; i++) begin
      ins = 3'(i);
      @(negedge clk);
      l4_en   = 1'b1;
      l4_addr = 2'(i);
      l4_data = {1'b1, ins, YTAB[i], 1'b1};
    end
    @(negedge clk);
    l4_en = 1'b0;
    s4    = 1'b1;
    @(posedge clk);
    #1 s4 = 1'b0;
    cyc = 1;
    while (!dn4 && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
    end
    checks++;
    if (cyc !== 4 * (SETTLE + 1) + 1 || v4 !== 16'd4 || e4 !== 16'd0) begin
      errors++; $display("FAIL full_depth got cyc=%0d vec=%0d err=%0d exp 13/4/0", cyc, v4, e4);
    end
    checks++;
    if (d4_in !== 3'd3 || p4 !== 1'b1 || fv4 !== 1'b0) begin
      errors++; $display("FAIL full_depth_end got in=%0d pass=%b fv=%b exp 3/1/0", d4_in, p4, fv4);
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    load_set(8'h00, 8'hFF);
    @(negedge clk);
    start = 1'b1;
    stop_on_err = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (dut_in !== 3'd4 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_run got in=%0d busy=%b exp 4/1", dut_in, busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, pass, fail_valid} !== 4'b0000 || vec_count !== 16'd0 ||
        err_count !== 16'd0 || dut_in !== 3'd0) begin
      errors++; $display("FAIL async_reset got bdpf=%b vec=%0d err=%0d in=%0d exp 0000/0/0/0",
                        {busy, done, pass, fail_valid}, vec_count, err_count, dut_in);
    end
    @(negedge clk);
    reset = 1'b0;
    run(1'b0, cyc);
    checks++;
    if (cyc !== 25 || vec_count !== 16'd8 || err_count !== 16'd0 || pass !== 1'b1) begin
      errors++; $display("FAIL after_reset got cyc=%0d vec=%0d err=%0d pass=%b exp 25/8/0/1",
                        cyc, vec_count, err_count, pass);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_single_error();
    test_stop_on_err();
    test_mask();
    test_back_to_back();
    test_empty();
    test_full_depth();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
